// File: rtl/ram_bist_pkg.sv
// Shared definitions for the March C- RAM BIST: element indices, per-element
// direction/pattern tables and controller state encodings.
package ram_bist_pkg;

  localparam logic [2:0] M0 = 3'd0;
  localparam logic [2:0] M1 = 3'd1;
  localparam logic [2:0] M2 = 3'd2;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [2:0] M5 = 3'd5;

  // Indexed by element; bit set = descending / inverted background.
  localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;
  localparam logic [7:0] ELEM_RD_INV = 8'b0001_0100;
  localparam logic [7:0] ELEM_WR_INV = 8'b0000_1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] bg_word(input logic [31:0] bg, input logic inv);
    return inv ? ~bg : bg;
  endfunction

endpackage

// File: rtl/ram_march_bist_if.sv
// DFFRAM port bundle: the BIST drives EN/WE/Di/A and receives registered Do.
interface ram_march_bist_if #(
  parameter int A_WIDTH = 8
);
  logic               ram_EN;
  logic [3:0]         ram_WE;
  logic [31:0]        ram_Di;
  logic [A_WIDTH-1:0] ram_A;
  logic [31:0]        ram_Do;

  modport master (
    output ram_EN,
    output ram_WE,
    output ram_Di,
    output ram_A,
    input  ram_Do
  );

  modport slave (
    input  ram_EN,
    input  ram_WE,
    input  ram_Di,
    input  ram_A,
    output ram_Do
  );
endinterface

// File: rtl/ram_bist_addr_gen.sv
// Up/down word-address counter covering 0..64*COLS-1 with load, step and
// end-of-sweep flag for the current direction.
module ram_bist_addr_gen #(
  parameter int COLS    = 1,
  parameter int A_WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               load,
  input  logic               load_down,
  input  logic               step,
  input  logic               down,
  output logic [A_WIDTH-1:0] addr,
  output logic               last
);

  localparam logic [A_WIDTH-1:0] TOP = A_WIDTH'(64 * COLS - 1);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? TOP : '0;
    end else if (step) begin
      addr <= down ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign last = down ? (addr == '0) : (addr == TOP);

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST initiator for one DFFRAM: runs M0..M5, stops at first read-back
// mismatch and reports address/data/element; a pass completes 10N+1 cycles after start.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int          COLS    = 1,
  parameter int          A_WIDTH = 8,
  parameter logic [31:0] BG      = 32'h5555_5555
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [A_WIDTH-1:0] fail_addr,
  output logic [31:0]        fail_data,
  output logic [2:0]         fail_elem,
  ram_march_bist_if.master   ram
);

  state_t             state_q, state_d;
  logic [2:0]         elem_q, elem_d, elem_nx;
  logic               phase_q, phase_d;
  logic               drain_q, drain_d;
  logic               en_q, en_d;
  logic [3:0]         we_q, we_d;
  logic [31:0]        di_q, di_d;
  logic               pass_q, pass_d;
  logic [A_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [31:0]        fail_data_q, fail_data_d;
  logic [2:0]         fail_elem_q, fail_elem_d;
  logic               cmp_vld_q, cmp_vld_d;
  logic [A_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic [31:0]        cmp_exp_q, cmp_exp_d;
  logic [2:0]         cmp_elem_q, cmp_elem_d;
  logic               ld, ld_down, stp;
  logic               cur_rd, mism;
  logic [A_WIDTH-1:0] addr;
  logic               last;

  ram_bist_addr_gen #(
    .COLS    (COLS),
    .A_WIDTH (A_WIDTH)
  ) u_addr_gen (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .load      (ld),
    .load_down (ld_down),
    .step      (stp),
    .down      (ELEM_DOWN[elem_q]),
    .addr      (addr),
    .last      (last)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      elem_q      <= M0;
      phase_q     <= 1'b0;
      drain_q     <= 1'b0;
      en_q        <= 1'b0;
      we_q        <= 4'h0;
      di_q        <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_elem_q <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= '0;
      cmp_elem_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      drain_q     <= drain_d;
      en_q        <= en_d;
      we_q        <= we_d;
      di_q        <= di_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_elem_q <= fail_elem_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_elem_q  <= cmp_elem_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    phase_d     = phase_q;
    drain_d     = drain_q;
    ld          = 1'b0;
    ld_down     = 1'b0;
    stp         = 1'b0;
    en_d        = 1'b0;
    we_d        = 4'h0;
    di_d        = di_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_elem_d = fail_elem_q;
    cmp_vld_d   = 1'b0;
    cmp_addr_d  = cmp_addr_q;
    cmp_exp_d   = cmp_exp_q;
    cmp_elem_d  = cmp_elem_q;
    elem_nx     = elem_q + 3'd1;
    // Any read issued this cycle is compared next cycle, when Do is valid.
    cur_rd      = (state_q == ST_RUN) && !drain_q &&
                  ((elem_q == M5) || ((elem_q != M0) && !phase_q));
    mism        = (state_q == ST_RUN) && cmp_vld_q && (ram.ram_Do != cmp_exp_q);

    case (state_q)
      ST_RUN: begin
        cmp_vld_d  = cur_rd;
        cmp_addr_d = addr;
        cmp_exp_d  = bg_word(BG, ELEM_RD_INV[elem_q]);
        cmp_elem_d = elem_q;
        if (mism) begin
          state_d     = ST_DONE;
          pass_d      = 1'b0;
          fail_addr_d = cmp_addr_q;
          fail_data_d = ram.ram_Do;
          fail_elem_d = cmp_elem_q;
          cmp_vld_d   = 1'b0;
        end else if (drain_q) begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
        end else if ((elem_q != M0) && (elem_q != M5) && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!last) begin
            stp = 1'b1;
          end else if (elem_q == M5) begin
            drain_d = 1'b1;
          end else begin
            elem_d  = elem_nx;
            ld      = 1'b1;
            ld_down = ELEM_DOWN[elem_nx];
          end
        end
      end
      default: begin
        if (start) begin
          state_d     = ST_RUN;
          elem_d      = M0;
          phase_d     = 1'b0;
          drain_d     = 1'b0;
          ld          = 1'b1;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          fail_elem_d = '0;
        end
      end
    endcase

    // RAM drive for the coming cycle is registered from the next sequencer state.
    if ((state_d == ST_RUN) && !drain_d) begin
      en_d = 1'b1;
      if ((elem_d == M0) || phase_d) begin
        we_d = 4'hF;
        di_d = bg_word(BG, ELEM_WR_INV[elem_d]);
      end
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign fail_addr  = fail_addr_q;
  assign fail_data  = fail_data_q;
  assign fail_elem  = fail_elem_q;
  assign ram.ram_EN = en_q;
  assign ram.ram_WE = we_q;
  assign ram.ram_Di = di_q;
  assign ram.ram_A  = addr;

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist: COLS=1 and COLS=2 instances, each on a
// behavioural registered-output DFFRAM model.
module tb_ram_march_bist;

  localparam int          N  = 64;
  localparam logic [31:0] BG = 32'h5555_5555;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        start1, start2;
  logic        busy1, done1, pass1, busy2, done2, pass2;
  logic [7:0]  fa1, fa2;
  logic [31:0] fd1, fd2;
  logic [2:0]  fe1, fe2;
  logic        stuck = 1'b0;
  logic [31:0] mem1 [0:255];
  logic [31:0] mem2 [0:255];

  int checks = 0;
  int errors = 0;
  int we_bad = 0;
  int seq_err = 0;
  int di_err = 0;
  int max_a2 = 0;
  int ed;
  int en_after;

  ram_march_bist_if #(.A_WIDTH(8)) ram1 ();
  ram_march_bist_if #(.A_WIDTH(8)) ram2 ();

  ram_march_bist #(.COLS(1), .A_WIDTH(8), .BG(BG)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .start(start1), .busy(busy1), .done(done1),
    .pass(pass1), .fail_addr(fa1), .fail_data(fd1), .fail_elem(fe1), .ram(ram1)
  );

  ram_march_bist #(.COLS(2), .A_WIDTH(8), .BG(BG)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .start(start2), .busy(busy2), .done(done2),
    .pass(pass2), .fail_addr(fa2), .fail_data(fd2), .fail_elem(fe2), .ram(ram2)
  );

  always #5 CLK = ~CLK;

  // RAM models; address 0x12 of ram1 can read back with bit 3 stuck at 1.
  always @(posedge CLK) begin
    logic [31:0] w;
    if (ram1.ram_EN) begin
      if (ram1.ram_WE != 4'h0) begin
        w = mem1[ram1.ram_A];
        for (int b = 0; b < 4; b++) if (ram1.ram_WE[b]) w[b*8 +: 8] = ram1.ram_Di[b*8 +: 8];
        mem1[ram1.ram_A] <= w;
      end else begin
        ram1.ram_Do <= mem1[ram1.ram_A] | ((stuck && ram1.ram_A == 8'h12) ? 32'h8 : 32'h0);
      end
    end
  end

  always @(posedge CLK) begin
    logic [31:0] w;
    if (ram2.ram_EN) begin
      if (ram2.ram_WE != 4'h0) begin
        w = mem2[ram2.ram_A];
        for (int b = 0; b < 4; b++) if (ram2.ram_WE[b]) w[b*8 +: 8] = ram2.ram_Di[b*8 +: 8];
        mem2[ram2.ram_A] <= w;
      end else begin
        ram2.ram_Do <= mem2[ram2.ram_A];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input int which);
    if (which == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge CLK); #1;
  endtask

  // Called #1 after edge 0; returns the edge index at which done is seen (-1 on timeout).
  task automatic wait_done(input int which, input int drop_at, input bit mon, output int edges);
    int c, e, off, p;
    logic xen, xdc;
    logic [3:0] xwe;
    logic [7:0] xa;
    logic [31:0] xdi;
    edges = -1;
    for (int k = 0; k <= 3000; k++) begin
      if (k == drop_at) begin start1 = 1'b0; start2 = 1'b0; end
      if ((which == 1) ? done1 : done2) begin edges = k; break; end
      if (which == 2 && ram2.ram_EN && int'(ram2.ram_A) > max_a2) max_a2 = int'(ram2.ram_A);
      if (mon) begin
        c = k + 1;
        xen = 1'b1; xwe = 4'h0; xa = 8'h0; xdc = 1'b0; xdi = 32'h0;
        if (c <= N) begin
          xa = 8'(c - 1); xwe = 4'hF; xdc = 1'b1; xdi = BG;
        end else if (c <= 9 * N) begin
          e = (c - N - 1) / (2 * N) + 1;
          off = (c - N - 1) % (2 * N);
          p = off / 2;
          xa = (e == 3 || e == 4) ? 8'(N - 1 - p) : 8'(p);
          if (off % 2 == 1) begin
            xwe = 4'hF; xdc = 1'b1;
            xdi = (e == 1 || e == 3) ? ~BG : BG;
          end
        end else if (c <= 10 * N) begin
          xa = 8'(c - 9 * N - 1);
        end else begin
          xen = 1'b0;
        end
        if (ram1.ram_WE != 4'h0 && ram1.ram_WE != 4'hF) we_bad++;
        if (ram1.ram_EN !== xen || (xen && (ram1.ram_WE !== xwe || ram1.ram_A !== xa))) seq_err++;
        if (xen && xdc && ram1.ram_Di !== xdi) di_err++;
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    RST_N = 1'b0; start1 = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_fail_addr", fa1, 0);
    chk("rst_fail_data", fd1, 0);
    chk("rst_fail_elem", fe1, 0);
    chk("rst_en", ram1.ram_EN, 0);
    chk("rst_we", ram1.ram_WE, 0);
    chk("rst_a", ram1.ram_A, 0);
    chk("rst_di", ram1.ram_Di, 0);
    RST_N = 1'b1;

    // Clean run with access-sequence monitor
    do_start(1);
    wait_done(1, 0, 1'b1, ed);
    chk("pass_edge", ed, 641);
    chk("pass_flag", pass1, 1);
    chk("pass_busy", busy1, 0);
    chk("mon_we_lanes", we_bad, 0);
    chk("mon_addr_seq", seq_err, 0);
    chk("mon_write_data", di_err, 0);
    @(posedge CLK); #1;
    chk("done_held", done1, 1);
    chk("idle_en", ram1.ram_EN, 0);

    // Restart from DONE, start held high well into the run
    do_start(1);
    chk("restart_done_clr", done1, 0);
    chk("restart_pass_clr", pass1, 0);
    chk("restart_busy", busy1, 1);
    wait_done(1, 600, 1'b0, ed);
    chk("held_start_edge", ed, 641);
    chk("held_start_pass", pass1, 1);

    // Stuck-at bit 3 on address 0x12
    stuck = 1'b1;
    do_start(1);
    wait_done(1, 0, 1'b0, ed);
    chk("fault_edge", ed, 102);
    chk("fault_pass", pass1, 0);
    chk("fault_elem", fe1, 1);
    chk("fault_addr", fa1, 8'h12);
    chk("fault_data", fd1, 32'h5555_555D);
    en_after = 0;
    repeat (5) begin
      if (ram1.ram_EN) en_after++;
      @(posedge CLK); #1;
    end
    chk("fault_no_access", en_after, 0);

    // Reset during M3
    stuck = 1'b0;
    do_start(1);
    chk("restart_fail_addr_clr", fa1, 0);
    chk("restart_fail_data_clr", fd1, 0);
    chk("restart_fail_elem_clr", fe1, 0);
    start1 = 1'b0;
    repeat (350) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    chk("midrst_busy", busy1, 0);
    chk("midrst_done", done1, 0);
    chk("midrst_en", ram1.ram_EN, 0);
    RST_N = 1'b1;
    do_start(1);
    wait_done(1, 0, 1'b0, ed);
    chk("after_rst_edge", ed, 641);
    chk("after_rst_pass", pass1, 1);

    // Two-column instance
    do_start(2);
    wait_done(2, 0, 1'b0, ed);
    chk("cols2_edge", ed, 1281);
    chk("cols2_pass", pass2, 1);
    chk("cols2_max_addr_ok", max_a2 <= 127, 1);
    chk("cols2_max_addr_reached", max_a2, 127);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
